// File: rtl/amp_pkg.sv
// amp_pkg: shared constants, gain table and FSM encoding for the amplitude scaler
package amp_pkg;
  localparam int AMP_MAX = 9;
  localparam int MIDSCALE = 128;
  // GAIN[k-1] = round(k*256/9); index 8 (code 9) is unity gain
  localparam logic [8:0] GAIN [AMP_MAX] = '{
    9'd28, 9'd57, 9'd85, 9'd114, 9'd142, 9'd171, 9'd199, 9'd228, 9'd256
  };
  typedef enum logic {ST_STABLE, ST_PENDING} state_t;
endpackage

// File: rtl/amp_gain_lut.sv
// amp_gain_lut: clamps amplitude codes into 1..AMP_MAX and maps a code to its gain
module amp_gain_lut
  import amp_pkg::*;
#(
  parameter int AMP_W = 5
) (
  input  logic [AMP_W-1:0] amplitude,
  input  logic [AMP_W-1:0] code,
  output logic [AMP_W-1:0] req,
  output logic [8:0]       gain
);
  function automatic logic [AMP_W-1:0] clamp(input logic [AMP_W-1:0] c);
    return c == '0 ? AMP_W'(1) : c > AMP_W'(AMP_MAX) ? AMP_W'(AMP_MAX) : c;
  endfunction
  logic [3:0] idx;
  always_comb begin
    req = clamp(amplitude);
    idx = 4'(clamp(code) - AMP_W'(1));
    gain = GAIN[idx];
  end
endmodule

// File: rtl/amplitude_scaler.sv
// amplitude_scaler: scales offset-binary DDS samples about midscale, switching gain only at period boundaries
module amplitude_scaler
  import amp_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          AMP_W   = 5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic              wave_valid,
  input  logic [DATA_W-1:0] wave_in,
  input  logic              wave_last,
  output logic              dac_valid,
  output logic [DATA_W-1:0] dac_out,
  output logic [AMP_W-1:0]  amp_active
);
  localparam int P_W = DATA_W + 10;
  localparam logic [DATA_W:0] MID = (DATA_W+1)'(MIDSCALE);
  localparam logic signed [P_W-1:0] QMID = P_W'(MIDSCALE);
  localparam logic signed [P_W-1:0] QMAX = P_W'((1 << DATA_W) - 1);
  state_t state, state_n;
  logic [AMP_W-1:0] amp_pend, pend_n, active_n, req;
  logic [15:0] cnt, cnt_n;
  logic [8:0] gain;
  logic boundary;
  amp_gain_lut #(.AMP_W(AMP_W)) lut (
    .amplitude(amplitude),
    .code(amp_active),
    .req(req),
    .gain(gain)
  );
  assign boundary = wave_valid && wave_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STABLE;
      amp_active <= AMP_W'(1);
      amp_pend <= AMP_W'(1);
      cnt <= '0;
    end else begin
      state <= state_n;
      amp_active <= active_n;
      amp_pend <= pend_n;
      cnt <= cnt_n;
    end
  end
  // A newer request always overrides the pending one; the boundary sample itself keeps the old gain
  always_comb begin
    state_n = state;
    active_n = amp_active;
    pend_n = amp_pend;
    cnt_n = cnt;
    if (state == ST_STABLE) begin
      if (req != amp_active) begin
        pend_n = req;
        cnt_n = '0;
        state_n = ST_PENDING;
      end
    end else if (boundary) begin
      active_n = amp_pend;
      if (req == amp_pend) state_n = ST_STABLE;
      else begin
        pend_n = req;
        cnt_n = '0;
      end
    end else if (req != amp_pend) begin
      pend_n = req;
      cnt_n = '0;
    end else if (cnt == TIMEOUT - 16'd1) begin
      active_n = amp_pend;
      state_n = ST_STABLE;
    end else cnt_n = cnt + 16'd1;
  end
  logic v1, v2;
  logic signed [DATA_W:0] s1;
  logic [8:0] g1;
  logic signed [P_W-1:0] p2, q;
  logic [DATA_W-1:0] r;
  always_comb begin
    q = (p2 >>> 8) + QMID;
    r = q < 0 ? '0 : q > QMAX ? '1 : q[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      g1 <= '0;
      p2 <= '0;
      dac_valid <= 1'b0;
      dac_out <= MID[DATA_W-1:0];
    end else begin
      v1 <= wave_valid;
      v2 <= v1;
      dac_valid <= v2;
      if (wave_valid) begin
        s1 <= $signed({1'b0, wave_in} - MID);
        g1 <= gain;
      end
      if (v1) p2 <= P_W'(s1) * $signed({{(P_W-9){1'b0}}, g1});
      if (v2) dac_out <= r;
    end
  end
endmodule

// File: tb/tb_amplitude_scaler.sv
// tb_amplitude_scaler: directed self-checking bench for amplitude_scaler
module tb_amplitude_scaler;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] amplitude;
  logic wave_valid, wave_last;
  logic [7:0] wave_in;
  logic dac_valid;
  logic [7:0] dac_out;
  logic [4:0] amp_active;
  int compared = 0;
  int mismatched = 0;

  amplitude_scaler dut (
    .clk(clk), .rst(rst), .amplitude(amplitude), .wave_valid(wave_valid),
    .wave_in(wave_in), .wave_last(wave_last), .dac_valid(dac_valid),
    .dac_out(dac_out), .amp_active(amp_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_boundary();
    tick();
    wave_valid = 1'b1; wave_last = 1'b1; wave_in = 8'd128;
    tick();
    wave_valid = 1'b0; wave_last = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; amplitude = 5'd1; wave_valid = 1'b0; wave_last = 1'b0; wave_in = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    compared++; if (dac_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0d expected 0", dac_valid); end
    compared++; if (dac_out !== 8'd128) begin mismatched++; $display("FAIL reset_dac: got %0d expected 128", dac_out); end
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL reset_amp: got %0d expected 1", amp_active); end
  endtask

  task automatic test_gain1();
    wave_valid = 1'b1; wave_in = 8'd255; tick();
    wave_in = 8'd128; tick();
    wave_in = 8'd0; tick();
    wave_valid = 1'b0;
    compared++; if (dac_valid !== 1'b1 || dac_out !== 8'd141) begin mismatched++; $display("FAIL g1_255: got v=%0d %0d expected v=1 141", dac_valid, dac_out); end
    tick();
    compared++; if (dac_valid !== 1'b1 || dac_out !== 8'd128) begin mismatched++; $display("FAIL g1_128: got v=%0d %0d expected v=1 128", dac_valid, dac_out); end
    tick();
    compared++; if (dac_valid !== 1'b1 || dac_out !== 8'd114) begin mismatched++; $display("FAIL g1_0: got v=%0d %0d expected v=1 114", dac_valid, dac_out); end
    tick();
    compared++; if (dac_valid !== 1'b0 || dac_out !== 8'd114) begin mismatched++; $display("FAIL g1_hold: got v=%0d %0d expected v=0 114", dac_valid, dac_out); end
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL g1_amp: got %0d expected 1", amp_active); end
  endtask

  task automatic test_identity();
    amplitude = 5'd9;
    apply_boundary();
    compared++; if (amp_active !== 5'd9) begin mismatched++; $display("FAIL id_amp: got %0d expected 9", amp_active); end
    for (int i = 0; i < 258; i++) begin
      wave_valid = i < 256;
      wave_in = 8'(i);
      tick();
      if (i >= 2) begin
        compared++;
        if (dac_valid !== 1'b1 || dac_out !== 8'(i - 2)) begin
          mismatched++;
          $display("FAIL id_ramp[%0d]: got v=%0d %0d expected v=1 %0d", i - 2, dac_valid, dac_out, i - 2);
        end
      end
    end
    wave_valid = 1'b0;
    tick();
    compared++; if (dac_valid !== 1'b0) begin mismatched++; $display("FAIL id_end: got %0d expected 0", dac_valid); end
  endtask

  task automatic test_step();
    amplitude = 5'd1;
    apply_boundary();
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL step_pre: got %0d expected 1", amp_active); end
    wave_valid = 1'b1; wave_in = 8'd255; tick();
    amplitude = 5'd5; tick();
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL step_hold: got %0d expected 1", amp_active); end
    wave_last = 1'b1; tick();
    wave_last = 1'b0;
    compared++; if (amp_active !== 5'd5) begin mismatched++; $display("FAIL step_amp: got %0d expected 5", amp_active); end
    compared++; if (dac_out !== 8'd141) begin mismatched++; $display("FAIL step_s0: got %0d expected 141", dac_out); end
    tick();
    compared++; if (dac_out !== 8'd141) begin mismatched++; $display("FAIL step_s1: got %0d expected 141", dac_out); end
    tick();
    wave_valid = 1'b0;
    compared++; if (dac_out !== 8'd141) begin mismatched++; $display("FAIL step_last: got %0d expected 141", dac_out); end
    tick();
    compared++; if (dac_out !== 8'd198) begin mismatched++; $display("FAIL step_s3: got %0d expected 198", dac_out); end
    tick();
    compared++; if (dac_valid !== 1'b1 || dac_out !== 8'd198) begin mismatched++; $display("FAIL step_s4: got v=%0d %0d expected v=1 198", dac_valid, dac_out); end
  endtask

  task automatic test_timeout();
    amplitude = 5'd1;
    apply_boundary();
    amplitude = 5'd4;
    repeat (50000) tick();
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL to_early: got %0d expected 1", amp_active); end
    tick();
    compared++; if (amp_active !== 5'd4) begin mismatched++; $display("FAIL to_fire: got %0d expected 4", amp_active); end
  endtask

  task automatic test_latest_wins();
    amplitude = 5'd2;
    apply_boundary();
    compared++; if (amp_active !== 5'd2) begin mismatched++; $display("FAIL lw_base: got %0d expected 2", amp_active); end
    amplitude = 5'd6; tick();
    compared++; if (amp_active !== 5'd2) begin mismatched++; $display("FAIL lw_6: got %0d expected 2", amp_active); end
    amplitude = 5'd3; tick();
    compared++; if (amp_active !== 5'd2) begin mismatched++; $display("FAIL lw_3: got %0d expected 2", amp_active); end
    wave_valid = 1'b1; wave_last = 1'b1; wave_in = 8'd128; tick();
    wave_valid = 1'b0; wave_last = 1'b0;
    compared++; if (amp_active !== 5'd3) begin mismatched++; $display("FAIL lw_apply: got %0d expected 3", amp_active); end
    amplitude = 5'd0;
    apply_boundary();
    compared++; if (amp_active !== 5'd1) begin mismatched++; $display("FAIL clamp_lo: got %0d expected 1", amp_active); end
    amplitude = 5'd15;
    apply_boundary();
    compared++; if (amp_active !== 5'd9) begin mismatched++; $display("FAIL clamp_hi: got %0d expected 9", amp_active); end
  endtask

  task automatic test_reset_flight();
    wave_valid = 1'b1; wave_in = 8'd0;
    repeat (3) tick();
    compared++; if (dac_valid !== 1'b1 || dac_out !== 8'd0) begin mismatched++; $display("FAIL rf_pre: got v=%0d %0d expected v=1 0", dac_valid, dac_out); end
    rst = 1'b1; wave_valid = 1'b0; tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (dac_valid !== 1'b0 || dac_out !== 8'd128 || amp_active !== 5'd1) begin
        mismatched++;
        $display("FAIL rf_post[%0d]: got v=%0d dac=%0d amp=%0d expected v=0 dac=128 amp=1", i, dac_valid, dac_out, amp_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gain1();
    test_identity();
    test_step();
    test_timeout();
    test_latest_wins();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
